imem_boot_loader: RTL

UART boot loader that sequences the single-cycle RISC-V core: holds the core in reset, receives a program image from the UART receiver, writes it word-by-word into instruction memory, verifies an XOR checksum, then releases the core. Sits between the UART RX byte interface, the instruction-memory write port and the core's active-high `reset` input at the top level of the UART project.

---
 rtl/imem_boot_loader_if.sv | 27 ++
 rtl/imem_boot_loader.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader_if.sv
// Boot loader bus: UART RX byte stream and reload request in, core reset,
// instruction-memory write port and status flags out.
interface imem_boot_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  reload;
  logic                  cpu_reset;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  done;
  logic                  error;

  // System side: feeds bytes and reload requests, observes the loader.
  modport master (
    output rx_valid, rx_data, reload,
    input  cpu_reset, imem_we, imem_addr, imem_wdata, done, error
  );

  // Loader side.
  modport slave (
    input  rx_valid, rx_data, reload,
    output cpu_reset, imem_we, imem_addr, imem_wdata, done, error
  );
endinterface

// File: rtl/imem_boot_loader.sv
// UART boot loader: keeps the core in reset, receives a framed program image
// (sync, 16-bit word count, little-endian words, XOR checksum), writes it into
// instruction memory and releases the core once the checksum matches.
module imem_boot_loader #(
  parameter int          ADDR_WIDTH     = 10,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             reset,
  imem_boot_loader_if.slave bus
);

  localparam int              TW       = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0]   TLAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]     CAPACITY = 17'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CHECK, RUN, ERROR} state_t;

  state_t                state, next_state;
  logic [7:0]            len_lo;
  logic [15:0]           len;
  logic [ADDR_WIDTH:0]   word_cnt;
  logic [1:0]            byte_idx;
  logic [23:0]           word_buf;
  logic [7:0]            checksum;
  logic [TW-1:0]         idle_cnt;
  logic                  cpu_reset_d, done_d, error_d;

  // A reload in the same cycle as a byte wins, so the byte is dropped.
  logic        rx_take;
  logic [15:0] rx_len;
  logic        timed;
  logic        timeout_hit;
  logic        last_word;

  assign rx_take     = bus.rx_valid & ~bus.reload;
  assign rx_len      = {bus.rx_data, len_lo};
  assign timed       = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CHECK);
  assign timeout_hit = timed & ~bus.rx_valid & (idle_cnt == TLAST);
  assign last_word   = (17'(word_cnt) + 17'd1) == {1'b0, len};

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic: reload first, then inter-byte timeout, then frame parsing.
  always_comb begin
    next_state = state;
    if (bus.reload) begin
      next_state = IDLE;
    end else if (timeout_hit) begin
      next_state = ERROR;
    end else begin
      case (state)
        IDLE:  if (rx_take && bus.rx_data == SYNC_BYTE) next_state = LEN0;
        LEN0:  if (rx_take) next_state = LEN1;
        LEN1:  if (rx_take) begin
                 if ({1'b0, rx_len} > CAPACITY) next_state = ERROR;
                 else if (rx_len == 16'd0)      next_state = CHECK;
                 else                           next_state = DATA;
               end
        DATA:  if (rx_take && byte_idx == 2'd3 && last_word) next_state = CHECK;
        CHECK: if (rx_take) next_state = (bus.rx_data == checksum) ? RUN : ERROR;
        RUN:   next_state = RUN;
        ERROR: if (rx_take && bus.rx_data == SYNC_BYTE) next_state = LEN0;
        default: next_state = IDLE;
      endcase
    end
  end

  // Status outputs follow the state being entered so they register in step with it.
  always_comb begin
    cpu_reset_d = (next_state != RUN);
    done_d      = (next_state == RUN);
    error_d     = (next_state == ERROR);
  end

  // Registered status outputs; the core is held in reset from power-up.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.cpu_reset <= 1'b1;
      bus.done      <= 1'b0;
      bus.error     <= 1'b0;
    end else begin
      bus.cpu_reset <= cpu_reset_d;
      bus.done      <= done_d;
      bus.error     <= error_d;
    end
  end

  // Inter-byte idle counter, restarted by any byte or state change and parked outside a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                                idle_cnt <= '0;
    else if (!timed || bus.rx_valid || next_state != state)   idle_cnt <= '0;
    else                                                       idle_cnt <= idle_cnt + 1'b1;
  end

  // Frame datapath: length capture, word assembly, checksum and memory write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_lo         <= '0;
      len            <= '0;
      word_cnt       <= '0;
      byte_idx       <= '0;
      word_buf       <= '0;
      checksum       <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      if (bus.imem_we) bus.imem_addr <= bus.imem_addr + 1'b1;
      if (rx_take) begin
        case (state)
          LEN0: len_lo <= bus.rx_data;
          LEN1: begin
            len           <= rx_len;
            word_cnt      <= '0;
            byte_idx      <= '0;
            checksum      <= '0;
            bus.imem_addr <= '0;
          end
          DATA: begin
            checksum <= checksum ^ bus.rx_data;
            byte_idx <= byte_idx + 1'b1;
            case (byte_idx)
              2'd0: word_buf[7:0]   <= bus.rx_data;
              2'd1: word_buf[15:8]  <= bus.rx_data;
              2'd2: word_buf[23:16] <= bus.rx_data;
              default: begin
                bus.imem_we    <= 1'b1;
                bus.imem_wdata <= {bus.rx_data, word_buf};
                word_cnt       <= word_cnt + 1'b1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule
